// File: rtl/mem_access_unit.sv
// Load/store initiator for the data port of the dual-port memory.
// Accepts one request at a time, optionally splits misaligned accesses into bytes, and returns a one-cycle response.
module mem_access_unit #(
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int MEM_SIZE         = 2097152,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_fault,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic                  mem_re,
   output logic [2:0]            mem_load_type,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int AW1 = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [2:0]            funct3_q, funct3_d;
   logic                  fault_q, fault_d;
   logic [1:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_fault_q, rsp_fault_d;

   // Request classification, evaluated only in the acceptance cycle.
   logic [2:0]     req_size;
   logic [AW1-1:0] req_last;
   logic           req_fault;
   logic           req_misaligned;
   logic [1:0]     last_idx;

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   req_size = 3'd1;
         2'b01:   req_size = 3'd2;
         default: req_size = 3'd4;
      endcase
   end

   // Last byte computed one bit wider than the address so a top-of-space access cannot wrap.
   assign req_last  = {1'b0, req_addr} + AW1'(req_size) - AW1'(1);
   assign req_fault = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                      (req_we && req_funct3[2]) || (req_last >= AW1'(MEM_SIZE));
   assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign last_idx  = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
   assign req_ready = (state_q == S_IDLE);

   always_comb begin
      // NOTE: every next-state value and output gets a default first, so no branch can infer a latch.
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      funct3_d      = funct3_q;
      fault_d       = fault_q;
      idx_d         = idx_q;
      asm_d         = asm_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_fault_d   = rsp_fault_q;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_we        = 1'b0;
      mem_be        = 4'b0000;
      mem_re        = 1'b0;
      mem_load_type = 3'b000;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               we_d     = req_we;
               funct3_d = req_funct3;
               idx_d    = 2'd0;
               fault_d  = req_fault;
               state_d  = (!req_fault && req_misaligned && SPLIT_MISALIGNED) ? S_SPLIT : S_ACCESS;
            end
         end

         S_ACCESS: begin
            if (!fault_q) begin
               mem_addr = addr_q;
               mem_re   = !we_q;
               mem_we   = we_q;
               if (we_q) begin
                  mem_wdata = wdata_q;
                  case (funct3_q[1:0])
                     2'b00:   mem_be = 4'b0001;
                     2'b01:   mem_be = 4'b0011;
                     default: mem_be = 4'b1111;
                  endcase
               end else begin
                  mem_load_type = funct3_q;
               end
            end
            rsp_valid_d = 1'b1;
            rsp_fault_d = fault_q;
            rsp_rdata_d = (fault_q || we_q) ? '0 : mem_rdata;
            state_d     = S_IDLE;
         end

         S_SPLIT: begin
            mem_addr = addr_q + ADDR_WIDTH'(idx_q);
            mem_be   = 4'b0001;
            if (we_q) begin
               mem_we    = 1'b1;
               mem_wdata = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{idx_q, 3'b000} +: 8]};
            end else begin
               mem_re        = 1'b1;
               mem_load_type = 3'b100;
               asm_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
            end
            if (idx_q == last_idx) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_fault_d = 1'b0;
               if (we_q)
                  rsp_rdata_d = '0;
               else if (funct3_q[1:0] == 2'b01)
                  rsp_rdata_d = {{(DATA_WIDTH-16){asm_d[15] & ~funct3_q[2]}}, asm_d[15:0]};
               else
                  rsp_rdata_d = asm_d;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         fault_q     <= 1'b0;
         idx_q       <= 2'd0;
         asm_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         fault_q     <= fault_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic,
// checked against a request-level byte-array reference model.
module tb_mem_access_unit;

   localparam int MEM_SIZE = 2097152;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic        mem_re;
   logic [2:0]  mem_load_type;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_unit #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE), .SPLIT_MISALIGNED(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
      .mem_re(mem_re), .mem_load_type(mem_load_type), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory data port: writes commit at the rising edge, reads are presented mid-cycle.
   logic [7:0] dmem [0:MEM_SIZE-1];

   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_be[0]) dmem[mem_addr + 32'd0] <= mem_wdata[7:0];
         if (mem_be[1]) dmem[mem_addr + 32'd1] <= mem_wdata[15:8];
         if (mem_be[2]) dmem[mem_addr + 32'd2] <= mem_wdata[23:16];
         if (mem_be[3]) dmem[mem_addr + 32'd3] <= mem_wdata[31:24];
      end
   end

   function automatic logic [7:0] dmem_byte(input logic [31:0] a);
      return (a < 32'(MEM_SIZE)) ? dmem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] mem_port_read(input logic [31:0] a, input logic [2:0] lt);
      logic [31:0] w;
      w = {dmem_byte(a + 32'd3), dmem_byte(a + 32'd2), dmem_byte(a + 32'd1), dmem_byte(a)};
      case (lt)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b010:  return w;
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk)
      mem_rdata <= mem_re ? mem_port_read(mem_addr, mem_load_type) : 32'hBAD0BAD0;

   // Reference model: architectural byte memory updated per completed request.
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] ref_byte(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   logic [31:0] cap_addr  [8];
   logic [31:0] cap_wdata [8];
   logic [3:0]  cap_be    [8];
   logic [2:0]  cap_lt    [8];
   logic        cap_re    [8];
   logic        cap_we    [8];
   int          cap_n;
   logic        cap_any;

   task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [2:0] f3);
      int          sz, lat, guard, exp_lat;
      logic        exp_f, mis;
      logic [31:0] exp_rd;
      sz     = 1 << f3[1:0];
      exp_f  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
               (longint'(a) + longint'(sz) - 1 >= longint'(MEM_SIZE));
      mis    = (int'(a) % sz) != 0;
      exp_lat = (!exp_f && mis) ? sz + 1 : 2;
      exp_rd = 32'h0;
      if (!exp_f && !we) begin
         for (int k = 0; k < sz; k++) exp_rd[8*k +: 8] = ref_byte(int'(a) + k);
         if (sz == 1 && !f3[2] && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;
         if (sz == 2 && !f3[2] && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
      end
      if (!exp_f && we)
         for (int k = 0; k < sz; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];

      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_addr   = a;
      req_wdata  = wd;
      req_we     = we;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);

      cap_n   = 0;
      cap_any = 1'b0;
      lat     = 0;
      do begin
         @(negedge clk);
         lat++;
         if (rsp_valid !== 1'b1 && cap_n < 8) begin
            cap_addr[cap_n]  = mem_addr;
            cap_wdata[cap_n] = mem_wdata;
            cap_be[cap_n]    = mem_be;
            cap_lt[cap_n]    = mem_load_type;
            cap_re[cap_n]    = mem_re;
            cap_we[cap_n]    = mem_we;
            cap_any = cap_any | mem_re | mem_we | (|mem_be) | (|mem_load_type);
            cap_n++;
         end
      end while (rsp_valid !== 1'b1 && lat < 12);

      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".fault"}, 32'(rsp_fault), 32'(exp_f));
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      logic [2:0]  rf;
      logic        rw;
      logic [2:0]  load_f3 [5];
      logic [2:0]  store_f3 [3];
      load_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      store_f3 = '{3'b000, 3'b001, 3'b010};

      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_funct3 = '0;
      repeat (3) @(negedge clk);
      chk("reset.ready", 32'(req_ready), 32'd1);
      chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset.strobes", 32'({mem_we, mem_re, mem_be, mem_load_type}), 32'd0);
      chk("reset.mem_addr", mem_addr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Aligned SW then back-to-back LW.
      do_req("sw_aligned", 32'h1000, 32'hDEADBEEF, 1'b1, 3'b010);
      chk("sw_aligned.be", 32'(cap_be[0]), 32'hF);
      chk("sw_aligned.we", 32'(cap_we[0]), 32'd1);
      chk("sw_aligned.addr", cap_addr[0], 32'h1000);
      chk("sw_aligned.wdata", cap_wdata[0], 32'hDEADBEEF);
      do_req("lw_aligned", 32'h1000, 32'h0, 1'b0, 3'b010);
      chk("lw_aligned.value", rsp_rdata, 32'hDEADBEEF);

      // Split halfword loads.
      do_req("sb_2001", 32'h2001, 32'h00000080, 1'b1, 3'b000);
      do_req("sb_2002", 32'h2002, 32'h000000FF, 1'b1, 3'b000);
      do_req("lh_split", 32'h2001, 32'h0, 1'b0, 3'b001);
      chk("lh_split.value", rsp_rdata, 32'hFFFFFF80);
      chk("lh_split.cycles", 32'(cap_n), 32'd2);
      chk("lh_split.addr0", cap_addr[0], 32'h2001);
      chk("lh_split.addr1", cap_addr[1], 32'h2002);
      chk("lh_split.lt0", 32'({cap_re[0], cap_lt[0], cap_be[0]}), 32'({1'b1, 3'b100, 4'b0001}));
      chk("lh_split.lt1", 32'({cap_re[1], cap_lt[1], cap_be[1]}), 32'({1'b1, 3'b100, 4'b0001}));
      do_req("lhu_split", 32'h2001, 32'h0, 1'b0, 3'b101);
      chk("lhu_split.value", rsp_rdata, 32'h0000FF80);

      // Split word store then split word load.
      do_req("sw_split", 32'h3003, 32'h11223344, 1'b1, 3'b010);
      chk("sw_split.cycles", 32'(cap_n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sw_split.addr%0d", i), cap_addr[i], 32'h3003 + 32'(i));
         chk($sformatf("sw_split.byte%0d", i), cap_wdata[i], 32'(8'h44 - 8'(i * 8'h11)));
         chk($sformatf("sw_split.be%0d", i), 32'({cap_we[i], cap_be[i]}), 32'h11);
      end
      do_req("lw_split", 32'h3003, 32'h0, 1'b0, 3'b010);
      chk("lw_split.value", rsp_rdata, 32'h11223344);

      // Faults: range, bad encodings.
      do_req("flt_range", 32'(MEM_SIZE - 2), 32'h0, 1'b0, 3'b010);
      chk("flt_range.strobes", 32'(cap_any), 32'd0);
      do_req("flt_f3_011", 32'h1000, 32'h0, 1'b0, 3'b011);
      chk("flt_f3_011.strobes", 32'(cap_any), 32'd0);
      do_req("flt_st_100", 32'h1000, 32'h55555555, 1'b1, 3'b100);
      chk("flt_st_100.strobes", 32'(cap_any), 32'd0);
      do_req("lw_after_flt", 32'h1000, 32'h0, 1'b0, 3'b010);

      // Top-of-memory boundary.
      do_req("sw_top", 32'(MEM_SIZE - 4), 32'hCAFE8001, 1'b1, 3'b010);
      do_req("lw_top", 32'(MEM_SIZE - 4), 32'h0, 1'b0, 3'b010);
      do_req("lb_last", 32'(MEM_SIZE - 1), 32'h0, 1'b0, 3'b000);
      do_req("lh_last", 32'(MEM_SIZE - 1), 32'h0, 1'b0, 3'b001);

      // Reset in the middle of a split store.
      do_req("pre_4000", 32'h4000, 32'hA5A5A5A5, 1'b1, 3'b010);
      do_req("pre_4004", 32'h4004, 32'h5A5A5A5A, 1'b1, 3'b010);
      req_valid = 1'b1; req_addr = 32'h4001; req_wdata = 32'h99887766; req_we = 1'b1; req_funct3 = 3'b010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      ref_mem[32'h4001] = 8'h66;
      ref_mem[32'h4002] = 8'h77;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.strobes", 32'({mem_we, mem_re, mem_be, mem_load_type}), 32'd0);
      chk("midrst.mem_addr", mem_addr, 32'd0);
      chk("midrst.mem_wdata", mem_wdata, 32'd0);
      chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst.ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cap_any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         cap_any = cap_any | rsp_valid;
      end
      chk("midrst.no_rsp", 32'(cap_any), 32'd0);
      do_req("midrst.lw4000", 32'h4000, 32'h0, 1'b0, 3'b010);
      chk("midrst.value", rsp_rdata, 32'hA57766A5);
      do_req("midrst.lbu4004", 32'h4004, 32'h0, 1'b0, 3'b100);

      // Random traffic in a prefilled window.
      for (int i = 0; i < 16; i++)
         do_req($sformatf("fill%0d", i), 32'h5000 + 32'(4 * i), $urandom, 1'b1, 3'b010);
      for (int i = 0; i < 48; i++) begin
         rw = 1'($urandom_range(0, 1));
         rf = rw ? store_f3[$urandom_range(0, 2)] : load_f3[$urandom_range(0, 4)];
         if ($urandom_range(0, 7) == 0) rf = 3'($urandom);
         ra = 32'h5000 + 32'($urandom_range(0, 60));
         do_req($sformatf("rnd%0d", i), ra, $urandom, rw, rf);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the data port of the unified dual-port memory, sitting between the MEM pipeline stage and the memory's data port. It accepts one load or store request at a time over a valid/ready handshake and drives address, write data, byte enables, read enable and load type. It splits misaligned halfword/word accesses into single-byte accesses, so the data path stays correct when the memory is later restricted to aligned accesses. It returns a one-cycle response carrying extended load data or a fault flag.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (fixed at 32 by the byte-lane logic)
- MEM_SIZE, 2097152, bytes of addressable memory; the bound for range faults
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into bytes; 0 = issue them as one access
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high exactly when state is IDLE
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte 0 = [7:0])
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: loads 000/001/010/100/101, stores 000/001/010
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
- rsp_fault  out  1  range or encoding fault; qualified by rsp_valid
- mem_addr  out  ADDR_WIDTH  memory data-port address
- mem_wdata  out  DATA_WIDTH  memory write data; lane k is written to mem_addr+k
- mem_we  out  1  write enable; the memory writes on the clk edge that ends the cycle
- mem_be  out  4  byte enables, relative to mem_addr
- mem_re  out  1  read enable
- mem_load_type  out  3  load type forwarded to the memory
- mem_rdata  in  DATA_WIDTH  combinational read data from the memory

## Operation
- States: IDLE, ACCESS, SPLIT.
- IDLE: on req_valid & req_ready, register the address, data, we and funct3.
  - Fault check → ACCESS with fault flag set.
  - Misaligned and SPLIT_MISALIGNED=1 → SPLIT with byte index 0.
  - Otherwise → ACCESS.
- Size: funct3[1:0] = 00 → 1 byte, 01 → 2 bytes, 10 → 4 bytes.
- Misaligned:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- Fault: any of
  - funct3 ∈ {011, 110, 111};
  - store with funct3[2]=1;
  - addr + size − 1 ≥ MEM_SIZE (computed at 33 bits, so no wrap).
- ACCESS, normal: mem_addr = addr; mem_re = !we; mem_we = we.
  - Loads: mem_load_type = funct3; mem_be = 0.
  - Stores: mem_be = 0001 / 0011 / 1111 for SB / SH / SW; mem_wdata = req_wdata; mem_load_type = 0.
  - Load result: mem_rdata is captured as-is, since the memory performs the extension.
  - Next state: IDLE.
- ACCESS, fault: all mem_* strobes stay low, no memory side effect. Next state: IDLE.
- SPLIT, byte index i from 0 to size−1:
  - mem_addr = addr + i, with mem_be = 0001.
  - Loads: mem_re = 1; mem_load_type = 100 (LBU); mem_rdata[7:0] is captured into assembly lane i.
  - Stores: mem_we = 1; mem_wdata = {24'b0, byte i of wdata}.
  - After i = size−1 → IDLE.
- Split load result: the assembly register is sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) from bit 15 or 31.
- Response: rsp_valid is registered and pulses in the cycle after the last ACCESS/SPLIT cycle, which is also the first IDLE cycle. A new request is accepted in that same cycle.
- No backpressure on the response; the consumer must take it.
- mem_* outputs are decoded from registered state only; there is no combinational path from req_* to mem_*. In IDLE every mem_* output is 0.
- Reset (asynchronous, any time):
  - state → IDLE;
  - all mem_* → 0 immediately;
  - rsp_valid, rsp_rdata, rsp_fault → 0;
  - assembly register → 0;
  - req_ready = 1 while in reset, but requests are ignored while rst_n is low.
- Reset mid-split store: bytes already written stay written; no response is issued.

## Timing
- Aligned or faulting request accepted in cycle T: ACCESS in T+1, rsp_valid in T+2, next request accepted no earlier than T+2.
  - Sustained throughput: one request per 2 cycles.
- Misaligned request, N bytes (2 or 4): SPLIT in T+1..T+N, rsp_valid in T+N+1.
- Store commit: at the rising edge that ends the ACCESS or SPLIT cycle.
- rsp_rdata and rsp_fault hold their value until the next response; they are meaningful only while rsp_valid = 1.
- req_* inputs must be stable only in the acceptance cycle.

## Test plan
- Reset then idle: rst_n low mid-stream → all mem_* = 0 and rsp_valid = 0 asynchronously; req_ready = 1 after release.
- Aligned SW then LW: SW 0xDEADBEEF @0x1000, then LW @0x1000 → ACCESS cycle shows mem_be = 1111; load responds at T+2 with rsp_rdata = 0xDEADBEEF and fault 0; back-to-back acceptance at the rsp_valid cycle.
- Split LH: memory bytes 0x80, 0xFF at 0x2001/0x2002; LH @0x2001 → two SPLIT cycles with mem_addr 0x2001 then 0x2002 and mem_load_type = 100; rsp at T+3 = 0xFFFFFF80. The same access as LHU returns 0x0000FF80.
- Split SW: SW 0x11223344 @0x3003 → four cycles with mem_addr 0x3003..0x3006, mem_wdata[7:0] = 44, 33, 22, 11, mem_be = 0001; a following LW @0x3003 returns 0x11223344 with latency 5.
- Faults:
  - LW @MEM_SIZE−2 → no mem strobes; rsp_fault = 1, rsp_rdata = 0 at T+2.
  - funct3 = 011 → same response.
  - store funct3 = 100 → same response.
- Reset during split store @0x4001 after 2 bytes → bytes 0x4001–0x4002 are updated and 0x4003–0x4004 are unchanged; no rsp_valid.
